// File: rtl/pllMap_pkg.sv
// Shared types, shadow reset image, field slice map and unpack helper for the PLL configuration loader.
package pllMap_pkg;

  localparam int unsigned SHADOW_WORDS  = 8;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned ADDR_W        = 3;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned COMMIT_CNT_W  = 8;

  // CTRL (word 0) bit positions
  localparam int unsigned CTRL_PLLEN       = 0;
  localparam int unsigned CTRL_COMMIT      = 1;
  localparam int unsigned CTRL_LDO_EN      = 2;
  localparam int unsigned CTRL_BYPASS      = 3;
  localparam int unsigned CTRL_CLKPOSTDIST = 4;

  // Word index and LSB position of every packed configuration field
  localparam int unsigned W_RATIO     = 1;  localparam int unsigned L_RATIO     = 0;
  localparam int unsigned W_ZDIV0     = 1;  localparam int unsigned L_ZDIV0     = 10;
  localparam int unsigned W_ZDIV1     = 1;  localparam int unsigned L_ZDIV1     = 20;
  localparam int unsigned W_SSC_STEP  = 2;  localparam int unsigned L_SSC_STEP  = 0;
  localparam int unsigned W_SSC_EN    = 2;  localparam int unsigned L_SSC_EN    = 24;
  localparam int unsigned W_SSC_PEAK  = 3;  localparam int unsigned L_SSC_PEAK  = 0;
  localparam int unsigned W_VCOTRIM   = 3;  localparam int unsigned L_VCOTRIM   = 9;
  localparam int unsigned W_LF_RSEL   = 4;  localparam int unsigned L_LF_RSEL   = 0;
  localparam int unsigned W_LF_CSEL   = 4;  localparam int unsigned L_LF_CSEL   = 4;
  localparam int unsigned W_CP_ICTRL  = 4;  localparam int unsigned L_CP_ICTRL  = 8;
  localparam int unsigned W_LOCK_CNT  = 5;  localparam int unsigned L_LOCK_CNT  = 0;
  localparam int unsigned W_OUT_DIV   = 6;  localparam int unsigned L_OUT_DIV   = 0;
  localparam int unsigned W_PFD_DLY   = 7;  localparam int unsigned L_PFD_DLY   = 0;

  typedef logic [SHADOW_WORDS-1:0][WORD_W-1:0] pllcfg_words_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_READY = 2'd1,
    ST_ISSUE = 2'd2,
    ST_GUARD = 2'd3
  } pllcfg_state_t;

  typedef struct packed {
    logic        en_read;
    logic        en_write;
    logic        pllen;
    logic        ldo_enable;
    logic        bypass;
    logic        clkpostdist;
    logic [9:0]  ratio;
    logic [9:0]  zdiv0_ratio;
    logic [9:0]  zdiv1_ratio;
    logic        ssc_en;
    logic [23:0] ssc_frac_step;
    logic [8:0]  ssc_cyc_to_peak_m1;
    logic [10:0] fz_vcotrim;
    logic [3:0]  lf_rsel;
    logic [3:0]  lf_csel;
    logic [4:0]  cp_ictrl;
    logic [15:0] lock_cnt;
    logic [7:0]  out_div;
    logic [3:0]  pfd_dly;
  } pllmap2pll;

  // Power-on shadow image, word 7 first
  localparam pllcfg_words_t PLLCFG_RST_WORDS = {
    32'h0000_0002,   // pfd_dly 2
    32'h0000_0001,   // out_div 1
    32'h0000_0400,   // lock_cnt 0x400
    32'h0000_0A48,   // cp_ictrl 0xA, lf_csel 4, lf_rsel 8
    32'h0007_93D8,   // fz_vcotrim 0x3C9, ssc_cyc_to_peak_m1 0x1D8
    32'h00E6_829A,   // ssc_en 0, ssc_frac_step 0xE6829A
    32'h0193_1CBC,   // zdiv1 0x19, zdiv0 0xC7, ratio 0xBC
    32'h0000_0001    // pllen 1
  };

  function automatic pllmap2pll pllcfg_unpack(input pllcfg_words_t words);
    pllmap2pll m;
    logic      unused_bits;
    m                    = '0;
    m.pllen              = words[0][CTRL_PLLEN];
    m.ldo_enable         = words[0][CTRL_LDO_EN];
    m.bypass             = words[0][CTRL_BYPASS];
    m.clkpostdist        = words[0][CTRL_CLKPOSTDIST];
    m.ratio              = words[W_RATIO][L_RATIO +: 10];
    m.zdiv0_ratio        = words[W_ZDIV0][L_ZDIV0 +: 10];
    m.zdiv1_ratio        = words[W_ZDIV1][L_ZDIV1 +: 10];
    m.ssc_frac_step      = words[W_SSC_STEP][L_SSC_STEP +: 24];
    m.ssc_en             = words[W_SSC_EN][L_SSC_EN];
    m.ssc_cyc_to_peak_m1 = words[W_SSC_PEAK][L_SSC_PEAK +: 9];
    m.fz_vcotrim         = words[W_VCOTRIM][L_VCOTRIM +: 11];
    m.lf_rsel            = words[W_LF_RSEL][L_LF_RSEL +: 4];
    m.lf_csel            = words[W_LF_CSEL][L_LF_CSEL +: 4];
    m.cp_ictrl           = words[W_CP_ICTRL][L_CP_ICTRL +: 5];
    m.lock_cnt           = words[W_LOCK_CNT][L_LOCK_CNT +: 16];
    m.out_div            = words[W_OUT_DIV][L_OUT_DIV +: 8];
    m.pfd_dly            = words[W_PFD_DLY][L_PFD_DLY +: 4];
    // Reserved shadow bits are stored but carry no field
    unused_bits = ^{words[0][31:5], words[0][CTRL_COMMIT], words[1][31:30],
                    words[2][31:25], words[3][31:20], words[4][31:13],
                    words[5][31:16], words[6][31:8], words[7][31:4]};
    return m;
  endfunction

  localparam pllmap2pll PLLMAP_RST = pllcfg_unpack(PLLCFG_RST_WORDS);

endpackage

// File: rtl/pllcfg_guard_cnt.sv
// Loadable down-counter that times both the boot hold-off and the post-issue settle window.
module pllcfg_guard_cnt
  import pllMap_pkg::*;
#(
  parameter int unsigned W       = CNT_W,
  parameter int unsigned RST_VAL = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  // Saturates at zero so an idle counter stays expired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= W'(RST_VAL);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/pll_cfg_loader.sv
// Shadow-register loader that issues PLL configuration to the PLL map core with boot and guard hold-offs.
// Optional readback port is enabled by defining PLLCFG_READBACK_EN.
module pll_cfg_loader
  import pllMap_pkg::*;
#(
  parameter int unsigned BOOT_CYC  = 4,
  parameter int unsigned GUARD_CYC = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WORD_W-1:0]       wr_data,
  output logic                    valid_o,
  output pllmap2pll               pllmap_o,
  output logic                    busy_o,
  output logic [COMMIT_CNT_W-1:0] commit_cnt_o
`ifdef PLLCFG_READBACK_EN
  ,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [WORD_W-1:0]       rd_data
`endif
);

  localparam logic [WORD_W-1:0] COMMIT_MASK = WORD_W'(1) << CTRL_COMMIT;
  localparam logic [CNT_W-1:0]  GUARD_LOAD  = CNT_W'(GUARD_CYC - 1);

  pllcfg_state_t            r_state;
  pllcfg_words_t            r_shadow;
  pllmap2pll                r_pllmap;
  logic                     r_wr_ready;
  logic                     r_valid;
  logic                     r_busy;
  logic [COMMIT_CNT_W-1:0]  r_commit_cnt;

  logic                     w_accept;
  logic                     w_ctrl_wr;
  logic                     w_commit;
  logic                     w_pllen_chg;
  logic                     w_issue;
  logic [WORD_W-1:0]        w_ctrl_new;
  pllcfg_words_t            w_issue_words;
  pllmap2pll                w_issue_map;
  logic                     w_cnt_load;
  logic                     w_cnt_zero;

  assign w_accept    = wr_valid & r_wr_ready;
  assign w_ctrl_wr   = w_accept && (wr_addr == ADDR_W'(0));
  assign w_commit    = wr_data[CTRL_COMMIT];
  assign w_ctrl_new  = wr_data & ~COMMIT_MASK;
  assign w_pllen_chg = wr_data[CTRL_PLLEN] != r_shadow[0][CTRL_PLLEN];
  assign w_issue     = w_ctrl_wr && (w_commit || w_pllen_chg);
  assign w_cnt_load  = (r_state == ST_ISSUE);

  // Issue image uses the incoming CTRL word alongside the stored field words
  always_comb begin
    w_issue_words          = r_shadow;
    w_issue_words[0]       = w_ctrl_new;
    w_issue_map            = pllcfg_unpack(w_issue_words);
    w_issue_map.en_read    = 1'b0;
    w_issue_map.en_write   = w_commit;
  end

  pllcfg_guard_cnt #(
    .W       (CNT_W),
    .RST_VAL (BOOT_CYC - 1)
  ) u_guard_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (GUARD_LOAD),
    .o_zero_c   (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BOOT;
      r_shadow     <= PLLCFG_RST_WORDS;
      r_pllmap     <= PLLMAP_RST;
      r_wr_ready   <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b1;
      r_commit_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          if (w_cnt_zero) begin
            r_state    <= ST_READY;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        ST_READY: begin
          if (w_accept) begin
            if (wr_addr == ADDR_W'(0)) begin
              r_shadow[0] <= w_ctrl_new;
            end else begin
              r_shadow[wr_addr] <= wr_data;
            end
          end
          if (w_issue) begin
            r_state    <= ST_ISSUE;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_valid    <= 1'b1;
            r_pllmap   <= w_issue_map;
            if (w_commit) begin
              r_commit_cnt <= r_commit_cnt + COMMIT_CNT_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          r_state           <= ST_GUARD;
          r_pllmap.en_write <= 1'b0;
        end
        ST_GUARD: begin
          if (w_cnt_zero) begin
            r_state    <= ST_READY;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign wr_ready     = r_wr_ready;
  assign valid_o      = r_valid;
  assign pllmap_o     = r_pllmap;
  assign busy_o       = r_busy;
  assign commit_cnt_o = r_commit_cnt;

`ifdef PLLCFG_READBACK_EN
  logic [WORD_W-1:0] r_rd_data;

  // Commit is never stored, mask kept so the read value is explicit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= (rd_addr == ADDR_W'(0)) ? (r_shadow[0] & ~COMMIT_MASK) : r_shadow[rd_addr];
    end
  end

  assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_pll_cfg_loader.sv
// Directed self-checking bench for pll_cfg_loader; covers boot, commit, pllen toggle, async reset and counter wrap.
module tb_pll_cfg_loader;
  import pllMap_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        valid_o;
  pllmap2pll   pllmap_o;
  logic        busy_o;
  logic [7:0]  commit_cnt_o;
`ifdef PLLCFG_READBACK_EN
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
`endif

  int n_vec = 0;
  int n_bad = 0;

  pll_cfg_loader #(.BOOT_CYC(4), .GUARD_CYC(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .valid_o      (valid_o),
    .pllmap_o     (pllmap_o),
    .busy_o       (busy_o),
    .commit_cnt_o (commit_cnt_o)
`ifdef PLLCFG_READBACK_EN
    ,
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for wr_ready at a falling edge, then presents one write for one cycle
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (wr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 32'd0;
`ifdef PLLCFG_READBACK_EN
    rd_en    = 1'b0;
    rd_addr  = 3'd0;
`endif
    repeat (3) @(negedge clk);

    // Reset values and decoded power-on map
    chk("rst_valid",    32'(valid_o),      32'd0);
    chk("rst_ready",    32'(wr_ready),     32'd0);
    chk("rst_busy",     32'(busy_o),       32'd1);
    chk("rst_cnt",      32'(commit_cnt_o), 32'd0);
    chk("rst_ratio",    32'(pllmap_o.ratio),         32'h0BC);
    chk("rst_zdiv0",    32'(pllmap_o.zdiv0_ratio),   32'h0C7);
    chk("rst_zdiv1",    32'(pllmap_o.zdiv1_ratio),   32'h019);
    chk("rst_ssc_step", 32'(pllmap_o.ssc_frac_step), 32'hE6829A);
    chk("rst_ssc_peak", 32'(pllmap_o.ssc_cyc_to_peak_m1), 32'h1D8);
    chk("rst_vcotrim",  32'(pllmap_o.fz_vcotrim),    32'h3C9);
    chk("rst_pllen",    32'(pllmap_o.pllen),         32'd1);
    chk("rst_en_write", 32'(pllmap_o.en_write),      32'd0);

    // Release with a word-1 write held: blocked for the 4 boot cycles
    rst_n    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 3'd1;
    wr_data  = 32'h0193_1CC8;
    chk("boot_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("boot_ready", 32'(wr_ready), 32'd0);
      chk("boot_valid", 32'(valid_o),  32'd0);
    end
    @(negedge clk);
    chk("boot_done_ready", 32'(wr_ready), 32'd1);
    chk("boot_done_busy",  32'(busy_o),   32'd0);
    @(negedge clk);
    chk("word1_no_valid",  32'(valid_o),        32'd0);
    chk("word1_map_hold",  32'(pllmap_o.ratio), 32'h0BC);
    wr_addr = 3'd0;
    wr_data = 32'h0000_0003;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("commit_valid",    32'(valid_o),           32'd1);
    chk("commit_en_write", 32'(pllmap_o.en_write), 32'd1);
    chk("commit_ratio",    32'(pllmap_o.ratio),    32'h0C8);
    chk("commit_pllen",    32'(pllmap_o.pllen),    32'd1);
    chk("commit_en_read",  32'(pllmap_o.en_read),  32'd0);
    chk("commit_cnt",      32'(commit_cnt_o),      32'd1);
    chk("commit_ready",    32'(wr_ready),          32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("guard_ready",    32'(wr_ready),          32'd0);
      chk("guard_valid",    32'(valid_o),           32'd0);
      chk("guard_en_write", 32'(pllmap_o.en_write), 32'd0);
      chk("guard_busy",     32'(busy_o),            32'd1);
    end
    @(negedge clk);
    chk("guard_done_ready", 32'(wr_ready),        32'd1);
    chk("guard_done_busy",  32'(busy_o),          32'd0);
    chk("guard_ratio_hold", 32'(pllmap_o.ratio),  32'h0C8);

    // CTRL write with same pllen and no commit: no issue
    do_write(3'd0, 32'h0000_0001);
    chk("nochg_valid", 32'(valid_o),  32'd0);
    chk("nochg_busy",  32'(busy_o),   32'd0);
    chk("nochg_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    chk("nochg_valid2", 32'(valid_o), 32'd0);
    chk("nochg_busy2",  32'(busy_o),  32'd0);

    // pllen 1 -> 0 without commit: issue with en_write=0
    do_write(3'd0, 32'h0000_0000);
    chk("dis_valid",    32'(valid_o),           32'd1);
    chk("dis_en_write", 32'(pllmap_o.en_write), 32'd0);
    chk("dis_pllen",    32'(pllmap_o.pllen),    32'd0);
    chk("dis_cnt",      32'(commit_cnt_o),      32'd1);
    @(negedge clk);
    chk("dis_valid_pulse", 32'(valid_o), 32'd0);

    // Commit re-enabling, then async reset during ISSUE
    do_write(3'd0, 32'h0000_0003);
    chk("re_valid", 32'(valid_o),        32'd1);
    chk("re_pllen", 32'(pllmap_o.pllen), 32'd1);
    chk("re_ratio", 32'(pllmap_o.ratio), 32'h0C8);
    chk("re_cnt",   32'(commit_cnt_o),   32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(valid_o),           32'd0);
    chk("arst_ready",    32'(wr_ready),          32'd0);
    chk("arst_busy",     32'(busy_o),            32'd1);
    chk("arst_cnt",      32'(commit_cnt_o),      32'd0);
    chk("arst_ratio",    32'(pllmap_o.ratio),    32'h0BC);
    chk("arst_en_write", 32'(pllmap_o.en_write), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reboot_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reboot_ready", 32'(wr_ready), 32'd0);
    end
    @(negedge clk);
    chk("reboot_done", 32'(wr_ready), 32'd1);

    // Shadow restored: commit now carries the default ratio
    do_write(3'd0, 32'h0000_0003);
    chk("post_rst_ratio", 32'(pllmap_o.ratio),    32'h0BC);
    chk("post_rst_ew",    32'(pllmap_o.en_write), 32'd1);
    chk("post_rst_cnt",   32'(commit_cnt_o),      32'd1);

    // Counter wrap after 256 commits
    for (int i = 0; i < 254; i++) begin
      do_write(3'd0, 32'h0000_0003);
    end
    chk("cnt_255", 32'(commit_cnt_o), 32'd255);
    do_write(3'd0, 32'h0000_0003);
    chk("cnt_wrap", 32'(commit_cnt_o), 32'd0);
    chk("cnt_wrap_valid", 32'(valid_o), 32'd1);

`ifdef PLLCFG_READBACK_EN
    repeat (6) @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = 3'd0;
    @(negedge clk);
    chk("rd_ctrl", rd_data, 32'h0000_0001);
    rd_addr = 3'd1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd_word1", rd_data, 32'h0193_1CBC);
    rd_addr = 3'd2;
    @(negedge clk);
    chk("rd_hold", rd_data, 32'h0193_1CBC);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_cfg_loader.md
PLL_CFG_LOADER -- requirements
Module: pll_cfg_loader

Interface
REQ-001 Parameter BOOT_CYC, default 4: cycles after reset release before the first write is accepted.
REQ-002 Parameter GUARD_CYC, default 3: settle cycles after each issue before the next write is accepted (minimum 1).
REQ-003 Port clk  in  1  block clock; one clock domain only.
REQ-004 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port wr_valid  in  1  a write request is present.
REQ-006 Port wr_ready  out  1  the loader can accept a write.
REQ-007 Port wr_addr  in  3  shadow word index.
REQ-008 Port wr_data  in  32  write data.
REQ-009 Port valid_o  out  1  one-cycle qualifier to the PLL map core.
REQ-010 Port pllmap_o  out  pllMap_pkg::pllmap2pll  configuration to the PLL map core.
REQ-011 Port busy_o  out  1  FSM is in BOOT, ISSUE or GUARD.
REQ-012 Port commit_cnt_o  out  8  number of committed writes, wrapping.

Function
REQ-013 Write handshake: a write transfers on a cycle where wr_valid=1 and wr_ready=1; wr_ready=1 only in READY.
REQ-014 Shadow: 8 words x 32 bits; word 0 is CTRL and words 1..7 hold packed configuration fields.
REQ-015 CTRL bits: [0] pllen, [1] commit (self-clearing; never stored), [2] ldo_enable, [3] bypass, [4] clkpostdist; all other bits are stored and ignored.
REQ-016 A write to word 1..7 in READY updates that word only and raises no valid_o.
REQ-017 FSM states: BOOT, READY, ISSUE, GUARD; state is BOOT at reset.
REQ-018 BOOT -> READY after BOOT_CYC cycles.
REQ-019 READY -> ISSUE on a CTRL write with commit=1, or on a CTRL write whose pllen differs from the stored pllen.
REQ-020 ISSUE lasts exactly 1 cycle and then goes to GUARD.
REQ-021 GUARD -> READY after GUARD_CYC cycles.
REQ-022 ISSUE: valid_o=1; pllmap_o.en_write=commit; pllmap_o.pllen=new CTRL pllen.
REQ-023 ISSUE latency: valid_o is high in the cycle after the accepting CTRL write.
REQ-024 pllmap_o is registered from the shadow words via pllcfg_unpack() and remains stable outside ISSUE.
REQ-025 pllmap_o.en_read is always 0; en_write is 0 outside ISSUE.
REQ-026 A CTRL write with commit=0 and unchanged pllen updates CTRL only and causes no ISSUE.
REQ-027 A commit with pllen=0 issues en_write=1 and pllen=0 together; the downstream disable takes priority and the loader does not treat this as an error.
REQ-028 commit_cnt_o increments in every ISSUE with en_write=1 and wraps from 255 to 0.

Reset
REQ-029 Reset values: valid_o=0, wr_ready=0, busy_o=1, commit_cnt_o=0.
REQ-030 Shadow words reset to PLLCFG_RST_WORDS, which decode to ratio 10'hBC, zdiv0_ratio 10'hC7, zdiv1_ratio 10'h19, pllen=1, ldo_enable=0, bypass=0, ssc_frac_step 24'hE6829A, ssc_cyc_to_peak_m1 9'h1D8, fz_vcotrim 11'h3C9, and remaining fields equal to the PLL control power-on defaults.
REQ-031 Reset asserted mid-ISSUE or mid-GUARD: valid_o drops immediately (asynchronous), the shadow returns to defaults, and the FSM restarts at BOOT.

Configuration
REQ-032 With PLLCFG_READBACK_EN defined, ports rd_en (in, 1), rd_addr (in, 3) and rd_data (out, 32) are present; rd_data is the addressed shadow word registered one cycle after rd_en=1, holds otherwise, and CTRL[1] reads 0.
REQ-033 With PLLCFG_READBACK_EN undefined, these ports and their logic are absent and all other behaviour is unchanged.

Structure
REQ-034 pllMap_pkg holds PLLCFG_RST_WORDS, the CTRL bit-index constants, the word-to-field slice map, the pllcfg_unpack() function and the FSM state enum.
REQ-035 One sub-module, pllcfg_guard_cnt: a loadable down-counter shared by BOOT and GUARD.

Verification
REQ-036 Release reset; wr_valid=1 held -> wr_ready=0 for 4 cycles; pllmap_o.ratio=10'hBC; valid_o=0.
REQ-037 Write word holding ratio=10'h0C8, then CTRL=0x3 -> next cycle valid_o=1, en_write=1, ratio=10'h0C8; wr_ready=0 for 4 cycles; commit_cnt_o=1.
REQ-038 In READY, write CTRL=0x0 (pllen 1->0) -> one-cycle valid_o with en_write=0, pllen=0; commit_cnt_o unchanged.
REQ-039 Write CTRL=0x1 (no change, no commit) -> no valid_o; busy_o stays 0.
REQ-040 Pulse rst_n low during GUARD -> outputs return to reset values immediately; ratio=10'hBC; BOOT restarts.
REQ-041 Issue 256 commits -> commit_cnt_o wraps to 0; with PLLCFG_READBACK_EN defined, rd_addr=0 reads CTRL with bit1=0.
